instr_fetch_unit: RTL

- Instruction fetch stage directly upstream of the control decoder.
- Holds the PC and issues one-at-a-time requests to instruction memory.
- Buffers the returned word in an IF/ID output slot plus a one-entry skid buffer.
- Presents instr/PC to decode with a valid/stall handshake; accepts redirects (branch/JAL/JALR targets) from execute.

---
 rtl/if_pkg.sv | 15 +
 rtl/if_skid_buf.sv | 78 +++++++
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
// IF_MISALIGN_CHK_EN adds the TRAP state used for misaligned redirect targets.
package if_pkg;

`ifdef IF_MISALIGN_CHK_EN
  typedef enum logic [2:0] {ST_FETCH, ST_WAIT, ST_HOLD, ST_DRAIN, ST_TRAP} if_state_e;
`else
  typedef enum logic [2:0] {ST_FETCH, ST_WAIT, ST_HOLD, ST_DRAIN} if_state_e;
`endif

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned PC_INC      = 4;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buf.sv
// IF/ID output slot plus one-entry skid buffer; a parked word is promoted
// into the slot in the same cycle the slot is consumed.
module if_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            park_i,
  input  logic            consume_i,
  input  logic            flush_i,
  input  logic [31:0]     rdata_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [31:0]     slot_instr_q, slot_instr_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;
  logic            slot_vld_q, slot_vld_d;
  logic [31:0]     buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic            buf_vld_q, buf_vld_d;

  always_comb begin
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    slot_vld_d   = slot_vld_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    buf_vld_d    = buf_vld_q;
    if (flush_i) begin
      slot_vld_d = 1'b0;
      buf_vld_d  = 1'b0;
    end else begin
      if (load_i) begin
        slot_instr_d = rdata_i;
        slot_pc_d    = pc_i;
        slot_vld_d   = 1'b1;
      end else if (consume_i && buf_vld_q) begin
        slot_instr_d = buf_instr_q;
        slot_pc_d    = buf_pc_q;
        buf_vld_d    = 1'b0;
      end else if (consume_i) begin
        slot_vld_d = 1'b0;
      end
      if (park_i) begin
        buf_instr_d = rdata_i;
        buf_pc_d    = pc_i;
        buf_vld_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      slot_vld_q   <= 1'b0;
      buf_instr_q  <= '0;
      buf_pc_q     <= '0;
      buf_vld_q    <= 1'b0;
    end else begin
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_vld_q   <= slot_vld_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      buf_vld_q    <= buf_vld_d;
    end
  end

  assign instr_o = slot_instr_q;
  assign pc_o    = slot_pc_q;
  assign valid_o = slot_vld_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one-outstanding imem requests, redirect handling, IF/ID slot.
// IF_MISALIGN_CHK_EN adds fetch_misalign_o and a TRAP state for misaligned redirect targets.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            instr_valid_o
`ifdef IF_MISALIGN_CHK_EN
  ,output logic           fetch_misalign_o
`endif
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_tgt;
  if_state_e       drain_exit_st, redir_exit_st;
  logic            consume, load, park, flush, busy;

`ifdef IF_MISALIGN_CHK_EN
  assign redir_tgt        = redirect_pc_i;
  // pc_q keeps the raw target, so a pending misaligned redirect is visible after the drain.
  assign drain_exit_st    = (|pc_q[1:0]) ? ST_TRAP : ST_FETCH;
  assign redir_exit_st    = (|redirect_pc_i[1:0]) ? ST_TRAP : ST_FETCH;
  assign fetch_misalign_o = (state_q == ST_TRAP);
`else
  logic unused_redir_lsb;
  assign redir_tgt        = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign drain_exit_st    = ST_FETCH;
  assign redir_exit_st    = ST_FETCH;
  assign unused_redir_lsb = ^redirect_pc_i[1:0];
`endif

  assign consume     = instr_valid_o && !stall_i;
  assign imem_addr_o = {pc_q[XLEN-1:2], 2'b00};
  assign pc_plus4_o  = pc_o + XLEN'(PC_INC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load       = 1'b0;
    park       = 1'b0;
    flush      = 1'b0;
    busy       = 1'b0;
    imem_req_o = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_o = rst_i;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          pc_d = pc_q + XLEN'(PC_INC);
          if (!instr_valid_o || consume) begin
            load    = 1'b1;
            state_d = ST_FETCH;
          end else begin
            park    = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (consume) state_d = ST_FETCH;
      end
      ST_DRAIN: begin
        if (imem_rvalid_i) state_d = drain_exit_st;
      end
`ifdef IF_MISALIGN_CHK_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_FETCH;
    endcase

    // A request still in flight must be drained before fetching the new target.
    if (redirect_i) begin
      load    = 1'b0;
      park    = 1'b0;
      flush   = 1'b1;
      pc_d    = redir_tgt;
      busy    = (state_q == ST_FETCH) ||
                (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !imem_rvalid_i);
      state_d = busy ? ST_DRAIN : redir_exit_st;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .park_i    (park),
    .consume_i (consume),
    .flush_i   (flush),
    .rdata_i   (imem_rdata_i),
    .pc_i      (pc_q),
    .instr_o   (instr_o),
    .pc_o      (pc_o),
    .valid_o   (instr_valid_o)
  );

endmodule
